i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_pkg.sv | 11 +
 rtl/i2s_clk_div.sv | 28 ++
 rtl/i2s_tx.sv | 81 ++++++++
 tb/tb_i2s_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmitter: sample/slot sizing and the
// frame-counter bit positions that produce the serial clocks.
package i2s_pkg;
   localparam int SAMPLE_W     = 24;
   localparam int SLOT_W       = 32;
   localparam int FRAME_CYCLES = 2048;
   localparam int CNT_W        = $clog2(FRAME_CYCLES);
   localparam int MCLK_BIT     = 1;
   localparam int SCLK_BIT     = 4;
   localparam int LRCK_BIT     = 10;
endpackage

// File: rtl/i2s_clk_div.sv
// Free-running frame counter plus the registered mclk/sclk/lrck taps.
// Every output comes from cnt through exactly one flop, so all three share the same latency.
module i2s_clk_div
   import i2s_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] cnt,
   output logic             mclk,
   output logic             sclk,
   output logic             lrck
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt  <= '0;
         mclk <= 1'b0;
         sclk <= 1'b0;
         lrck <= 1'b0;
      end else begin
         cnt  <= cnt + CNT_W'(1);
         mclk <= cnt[MCLK_BIT];
         sclk <= cnt[SCLK_BIT];
         lrck <= cnt[LRCK_BIT];
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-deep holding register feeding an active stereo pair
// that is serialised MSB first with the standard one-bit delay after each lrck edge.
module i2s_tx #(
   parameter int SAMPLE_W = i2s_pkg::SAMPLE_W,
   parameter int SLOT_W   = i2s_pkg::SLOT_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] in_left,
   input  logic [SAMPLE_W-1:0] in_right,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                underrun,
   output logic                mclk,
   output logic                sclk,
   output logic                lrck,
   output logic                sdata
);
   import i2s_pkg::*;

   localparam int SLOT_BITS = $clog2(SLOT_W);

   logic [CNT_W-1:0]     cnt;
   logic                 frame_end;
   logic                 accept;
   logic                 hold_valid;
   logic [SAMPLE_W-1:0]  hold_l, hold_r;
   logic [SAMPLE_W-1:0]  act_l, act_r;
   logic [SAMPLE_W-1:0]  sample_sel, sample_shift;
   logic [SLOT_BITS-1:0] slot;
   logic                 sdata_next;

   i2s_clk_div u_clk_div (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (cnt),
      .mclk  (mclk),
      .sclk  (sclk),
      .lrck  (lrck)
   );

   // Handshake: a pair transfers on any cycle with in_valid & in_ready high; in_ready is
   // low while the holding register is full, and in_valid is then ignored (no overwrite).
   assign frame_end = (cnt == CNT_W'(FRAME_CYCLES - 1));
   assign in_ready  = rst_n & ~hold_valid;
   assign accept    = in_valid & in_ready;
   assign underrun  = rst_n & frame_end & ~hold_valid;
   assign slot      = cnt[SCLK_BIT+SLOT_BITS : SCLK_BIT+1];

   // Slot 0 is the I2S delay bit; slots past the sample width are padding.
   always_comb begin
      sample_sel   = cnt[LRCK_BIT] ? act_r : act_l;
      sample_shift = sample_sel << (slot - SLOT_BITS'(1));
      sdata_next   = 1'b0;
      if (slot != '0 && 32'(slot) <= SAMPLE_W)
         sdata_next = sample_shift[SAMPLE_W-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_l     <= '0;
         hold_r     <= '0;
         act_l      <= '0;
         act_r      <= '0;
         sdata      <= 1'b0;
      end else begin
         sdata <= sdata_next;
         if (accept) begin
            hold_l     <= in_left;
            hold_r     <= in_right;
            hold_valid <= 1'b1;
         end else if (frame_end && hold_valid) begin
            act_l      <= hold_l;
            act_r      <= hold_r;
            hold_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-level reference model compared every cycle, plus
// literal expectations on captured frame words, clock periods and handshake counts.
module tb_i2s_tx;
   localparam int SAMPLE_W = 24;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [SAMPLE_W-1:0] in_left = '0;
   logic [SAMPLE_W-1:0] in_right = '0;
   logic                in_valid = 1'b0;
   logic                in_ready, underrun, mclk, sclk, lrck, sdata;

   i2s_tx #(.SAMPLE_W(SAMPLE_W), .SLOT_W(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_left  (in_left),
      .in_right (in_right),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .underrun (underrun),
      .mclk     (mclk),
      .sclk     (sclk),
      .lrck     (lrck),
      .sdata    (sdata)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int                  m_cnt = 0;
   int                  m_out_cnt = -1;
   bit                  m_hold_v = 1'b0;
   logic [SAMPLE_W-1:0] m_hold_l = '0, m_hold_r = '0, m_act_l = '0, m_act_r = '0;
   logic                e_mclk = 1'b0, e_sclk = 1'b0, e_lrck = 1'b0, e_sdata = 1'b0;
   bit                  started = 1'b0;
   bit                  m_acc;

   function automatic logic exp_bit(input logic [SAMPLE_W-1:0] s, input int c);
      int slot;
      slot = (c / 32) % 32;
      if (slot >= 1 && slot <= SAMPLE_W) return s[SAMPLE_W - slot];
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      started = 1'b1;
      if (!rst_n) begin
         m_cnt = 0; m_out_cnt = -1; m_hold_v = 1'b0;
         m_hold_l = '0; m_hold_r = '0; m_act_l = '0; m_act_r = '0;
         e_mclk = 1'b0; e_sclk = 1'b0; e_lrck = 1'b0; e_sdata = 1'b0;
      end else begin
         m_acc   = in_valid && !m_hold_v;
         e_mclk  = ((m_cnt / 2) % 2) == 1;
         e_sclk  = ((m_cnt / 16) % 2) == 1;
         e_lrck  = (m_cnt / 1024) == 1;
         e_sdata = exp_bit((m_cnt < 1024) ? m_act_l : m_act_r, m_cnt);
         m_out_cnt = m_cnt;
         if (m_cnt == 2047 && m_hold_v) begin
            m_act_l = m_hold_l; m_act_r = m_hold_r; m_hold_v = 1'b0;
         end
         if (m_acc) begin
            m_hold_l = in_left; m_hold_r = in_right; m_hold_v = 1'b1;
         end
         m_cnt = (m_cnt + 1) % 2048;
      end
   end

   // ---------------- scoreboard: every cycle ----------------
   always @(negedge clk) begin
      if (started) begin
         chk("mclk", mclk, e_mclk);
         chk("sclk", sclk, e_sclk);
         chk("lrck", lrck, e_lrck);
         chk("sdata", sdata, e_sdata);
         chk("in_ready", in_ready, rst_n && !m_hold_v);
         chk("underrun", underrun, rst_n && m_cnt == 2047 && !m_hold_v);
      end
   end

   // ---------------- observers: frame capture, periods, counts ----------------
   logic [31:0] cap_l = '0, cap_r = '0, done_l = '0, done_r = '0;
   int frame_done = 0, n_hs = 0, n_ur = 0, cyc = 0;
   int t_mclk = -1, t_sclk = -1, t_lrck = -1;
   int per_mclk = 0, per_sclk = 0, per_lrck = 0;
   logic p_mclk = 1'b0, p_sclk = 1'b0, p_lrck = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (in_valid && in_ready) n_hs++;
      if (underrun) n_ur++;
      if (mclk && !p_mclk) begin if (t_mclk >= 0) per_mclk = cyc - t_mclk; t_mclk = cyc; end
      if (sclk && !p_sclk) begin if (t_sclk >= 0) per_sclk = cyc - t_sclk; t_sclk = cyc; end
      if (lrck && !p_lrck) begin if (t_lrck >= 0) per_lrck = cyc - t_lrck; t_lrck = cyc; end
      p_mclk = mclk; p_sclk = sclk; p_lrck = lrck;
      if (m_out_cnt < 0) begin
         cap_l = '0; cap_r = '0;
      end else if (m_out_cnt % 32 == 16) begin
         if (m_out_cnt >= 1024) cap_r[31 - (m_out_cnt / 32) % 32] = sdata;
         else                   cap_l[31 - (m_out_cnt / 32) % 32] = sdata;
      end
      if (m_out_cnt == 2047) begin
         done_l = cap_l; done_r = cap_r; frame_done++;
      end
   end

   // ---------------- random data driver ----------------
   bit rand_data = 1'b0;
   always @(posedge clk) begin
      #2;
      if (rand_data) begin
         in_left  = SAMPLE_W'($urandom);
         in_right = SAMPLE_W'($urandom);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_frames(input int n);
      int target;
      int b;
      target = frame_done + n;
      b = 0;
      while (frame_done < target && b < n * 2048 + 4096) begin
         @(posedge clk); #1;
         b++;
      end
      chk("wait_frames_timeout", frame_done >= target, 1);
   endtask

   task automatic wait_cnt(input int c);
      int b;
      b = 0;
      while (m_cnt != c && b < 5000) begin
         @(posedge clk); #1;
         b++;
      end
      chk("wait_cnt_timeout", b < 5000, 1);
   endtask

   // ---------------- main sequence ----------------
   int u0, h0;

   initial begin
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_outputs", {mclk, sclk, lrck, sdata, underrun}, 0);

      // release reset and offer one known pair immediately
      @(posedge clk); #1;
      rst_n = 1'b1; in_left = 24'h800001; in_right = 24'h7FFFFE; in_valid = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;

      wait_frames(1);
      chk("frame0_left", done_l, 32'h0);
      chk("frame0_right", done_r, 32'h0);
      wait_frames(1);
      chk("pair_left", done_l, 32'h4000_0080);
      chk("pair_right", done_r, 32'h3FFF_FF00);

      // starve: previous pair repeats, one underrun per frame
      u0 = n_ur;
      wait_frames(2);
      chk("underrun_count", n_ur - u0, 2);
      chk("repeat_left", done_l, 32'h4000_0080);
      chk("repeat_right", done_r, 32'h3FFF_FF00);
      chk("mclk_period", per_mclk, 4);
      chk("sclk_period", per_sclk, 32);
      chk("lrck_period", per_lrck, 2048);

      // backpressure: valid held high with fresh data every cycle
      rand_data = 1'b1; in_valid = 1'b1;
      wait_frames(1);
      h0 = n_hs;
      wait_frames(3);
      chk("bp_consumed", n_hs - h0, 3);
      rand_data = 1'b0; in_valid = 1'b0;
      wait_frames(2);

      // first pair offered exactly on the frame-load cycle
      wait_cnt(2047);
      in_left = 24'h123456; in_right = 24'hABCDEF; in_valid = 1'b1;
      @(negedge clk);
      chk("boundary_underrun", underrun, 1);
      chk("boundary_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_frames(2);
      chk("boundary_not_early", done_l == 32'h091A_2B00, 0);
      wait_frames(1);
      chk("boundary_left", done_l, 32'h091A_2B00);
      chk("boundary_right", done_r, 32'h55E6_F780);

      // mid-frame reset with a pair pending in the holding register
      in_left = 24'h5A5A5A; in_right = 24'hA5A5A5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_cnt(700);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("midrst_in_ready", in_ready, 0);
         chk("midrst_outputs", {mclk, sclk, lrck, sdata, underrun}, 0);
      end
      #1 rst_n = 1'b1;
      u0 = n_ur;
      wait_frames(1);
      chk("postrst_f0_left", done_l, 32'h0);
      chk("postrst_f0_right", done_r, 32'h0);
      wait_frames(1);
      chk("discard_left", done_l, 32'h0);
      chk("discard_right", done_r, 32'h0);
      chk("postrst_underruns", n_ur - u0, 2);

      // random traffic against the model
      rand_data = 1'b1;
      for (int i = 0; i < 3 * 2048; i++) begin
         @(posedge clk); #1;
         in_valid = ($urandom_range(0, 999) < 2);
      end
      in_valid = 1'b0; rand_data = 1'b0;
      repeat (10) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
